router_pkt_tx: RTL and testbench

//  Packet transmitter that drives the 1x3 router's input port: the source end of the

---
 rtl/router_pkg.sv | 23 ++
 rtl/router_tx_buf.sv | 31 +++
 rtl/router_pkt_tx.sv | 159 +++++++++++++++
 tb/tb_router_pkt_tx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter: state encoding,
// header packing and byte width.
package router_pkg;

    localparam int         HDR_W        = 8;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    typedef logic [2:0] tx_state_t;

    localparam tx_state_t ST_IDLE    = 3'd0;
    localparam tx_state_t ST_HEADER  = 3'd1;
    localparam tx_state_t ST_PAYLOAD = 3'd2;
    localparam tx_state_t ST_PARITY  = 3'd3;
    localparam tx_state_t ST_GAP     = 3'd4;

    // len_f and addr_f arrive zero-extended; addr_w is the address field width.
    function automatic logic [HDR_W-1:0] pack_header(input logic [HDR_W-1:0] len_f,
                                                     input logic [HDR_W-1:0] addr_f,
                                                     input int unsigned      addr_w);
        return (len_f << addr_w) | addr_f;
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: one write port, one registered read port. A write to the
// address being read on the same edge is forwarded to the read data.
module router_tx_buf
    import router_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [HDR_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [HDR_W-1:0]  rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [HDR_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/router_pkt_tx.sv
// Source end of the router byte protocol: sends header, payload from the
// internal buffer, then an XOR parity byte with pkt_valid low.
//
//  state      | meaning
//  -----------+-----------------------------------------------
//  ST_IDLE    | waiting for start; buffer writable
//  ST_HEADER  | header {len, addr} presented
//  ST_PAYLOAD | payload byte idx-1 presented
//  ST_PARITY  | parity byte presented, pkt_valid low
//  ST_GAP     | enforced idle gap before the next start
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int LEN_W      = 6,
    parameter int ADDR_W     = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              corrupt_parity,
    input  logic              wr_en,
    input  logic [LEN_W-1:0]  wr_addr,
    input  logic [HDR_W-1:0]  wr_data,
    input  logic              busy,
    output logic              pkt_valid,
    output logic [HDR_W-1:0]  data_out,
    output logic              idle,
    output logic              done,
    output logic              err
);

    localparam int              GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    tx_state_t         state;
    logic [LEN_W-1:0]  idx;
    logic [LEN_W-1:0]  idx_next;
    logic [LEN_W-1:0]  len_q;
    logic              corrupt_q;
    logic [HDR_W-1:0]  acc;
    logic [HDR_W-1:0]  acc_upd;
    logic [GAP_W-1:0]  gap_cnt;
    logic [HDR_W-1:0]  rd_data;
    logic              consume;
    logic              req_valid;
    logic              buf_wr_en;

    assign consume   = !busy;
    assign req_valid = (addr != ADDR_W'(ADDR_INVALID)) && (len != '0);
    assign buf_wr_en = wr_en && idle && !reset;
    assign acc_upd   = acc ^ data_out;

    // idx_next doubles as the read address, so rd_data always holds buf[idx]
    // and a byte is ready on every consume without a bubble.
    always_comb begin
        idx_next = idx;
        case (state)
            ST_IDLE:    idx_next = '0;
            ST_HEADER:  if (consume) idx_next = LEN_W'(1);
            ST_PAYLOAD: if (consume && (idx != len_q)) idx_next = idx + 1'b1;
            default:    idx_next = idx;
        endcase
        if (reset) begin
            idx_next = '0;
        end
    end

    router_tx_buf #(
        .ADDR_W (LEN_W)
    ) u_buf (
        .clock   (clock),
        .wr_en   (buf_wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (idx_next),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            len_q     <= '0;
            corrupt_q <= 1'b0;
            acc       <= '0;
            gap_cnt   <= '0;
            pkt_valid <= 1'b0;
            data_out  <= '0;
            idle      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            idx  <= idx_next;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (req_valid) begin
                            len_q     <= len;
                            corrupt_q <= corrupt_parity;
                            data_out  <= pack_header(HDR_W'(len), HDR_W'(addr), ADDR_W);
                            pkt_valid <= 1'b1;
                            idle      <= 1'b0;
                            state     <= ST_HEADER;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_HEADER: begin
                    if (consume) begin
                        acc      <= data_out;
                        data_out <= rd_data;
                        state    <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (consume) begin
                        acc <= acc_upd;
                        if (idx != len_q) begin
                            data_out <= rd_data;
                        end else begin
                            data_out  <= acc_upd ^ {{(HDR_W-1){1'b0}}, corrupt_q};
                            pkt_valid <= 1'b0;
                            state     <= ST_PARITY;
                        end
                    end
                end
                ST_PARITY: begin
                    if (consume) begin
                        data_out <= '0;
                        done     <= 1'b1;
                        gap_cnt  <= GAP_LOAD;
                        state    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        idle  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    pkt_valid <= 1'b0;
                    data_out  <= '0;
                    idle      <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: directed and randomized packets checked against a
// byte-list model built from the buffer contents.
module tb_router_pkt_tx;

    localparam int LEN_W      = 6;
    localparam int ADDR_W     = 2;
    localparam int GAP_CYCLES = 2;
    localparam int DEPTH      = 2 ** LEN_W;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [LEN_W-1:0]  len = '0;
    logic              corrupt_parity = 1'b0;
    logic              wr_en = 1'b0;
    logic [LEN_W-1:0]  wr_addr = '0;
    logic [7:0]        wr_data = '0;
    logic              busy = 1'b0;
    logic              pkt_valid;
    logic [7:0]        data_out;
    logic              idle;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_mem [DEPTH];

    always #5 clock = ~clock;

    router_pkt_tx #(
        .LEN_W      (LEN_W),
        .ADDR_W     (ADDR_W),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .addr           (addr),
        .len            (len),
        .corrupt_parity (corrupt_parity),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .busy           (busy),
        .pkt_valid      (pkt_valid),
        .data_out       (data_out),
        .idle           (idle),
        .done           (done),
        .err            (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_buf(input logic [LEN_W-1:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        model_mem[a] = d;
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    // Cycles of busy=1 held before byte k of an nbytes-long packet is consumed.
    function automatic int stall_for(input int mode, input int k, input int nbytes);
        if (mode == 1) return (k == 1) ? 3 : ((k == nbytes - 1) ? 2 : 0);
        if (mode == 2) return int'($urandom_range(0, 2));
        return 0;
    endfunction

    task automatic run_packet(input logic [1:0] a, input logic [5:0] n, input logic c,
                              input int mode, input bit gap_start, input bit noise,
                              input bit same_edge);
        logic [7:0] exp_b[$];
        logic       exp_v[$];
        logic [7:0] par;
        int         nb;
        check("idle_before_start", idle, 1);
        start          = 1'b1;
        addr           = a;
        len            = n;
        corrupt_parity = c;
        if (same_edge) begin
            wr_en   = 1'b1;
            wr_addr = 6'($urandom_range(0, int'(n) - 1));
            wr_data = 8'($urandom);
            model_mem[wr_addr] = wr_data;
        end
        par = {n, a};
        exp_b.push_back({n, a});
        exp_v.push_back(1'b1);
        for (int i = 0; i < int'(n); i++) begin
            exp_b.push_back(model_mem[i]);
            exp_v.push_back(1'b1);
            par ^= model_mem[i];
        end
        exp_b.push_back(par ^ {7'b0, c});
        exp_v.push_back(1'b0);
        nb = exp_b.size();
        @(negedge clock);
        start = 1'b0;
        wr_en = 1'b0;
        for (int k = 0; k < nb; k++) begin
            int st;
            st = stall_for(mode, k, nb);
            for (int s = 0; s <= st; s++) begin
                check($sformatf("byte%0d", k), data_out, exp_b[k]);
                check($sformatf("pkt_valid%0d", k), pkt_valid, exp_v[k]);
                check("done_mid", done, 0);
                check("err_mid", err, 0);
                busy = (s < st);
                if (noise) begin
                    start   = 1'($urandom_range(0, 1));
                    addr    = 2'($urandom_range(0, 3));
                    len     = 6'($urandom);
                    wr_en   = 1'($urandom_range(0, 1));
                    wr_addr = 6'($urandom);
                    wr_data = 8'($urandom);
                end
                @(negedge clock);
            end
        end
        busy  = 1'b0;
        start = 1'b0;
        wr_en = 1'b0;
        check("done_pulse", done, 1);
        check("pkt_valid_after", pkt_valid, 0);
        check("data_out_after", data_out, 0);
        check("idle_gap0", idle, 0);
        check("err_after", err, 0);
        if (gap_start) begin
            start = 1'b1;
            addr  = 2'd1;
            len   = 6'd5;
        end
        for (int g = 1; g < GAP_CYCLES; g++) begin
            @(negedge clock);
            check("done_gap", done, 0);
            check("idle_gap", idle, 0);
            check("pkt_valid_gap", pkt_valid, 0);
        end
        @(negedge clock);
        start = 1'b0;
        check("idle_after_gap", idle, 1);
        check("done_after_gap", done, 0);
        check("pkt_valid_after_gap", pkt_valid, 0);
        check("err_after_gap", err, 0);
    endtask

    task automatic try_bad(input logic [1:0] a, input logic [5:0] n);
        start = 1'b1;
        addr  = a;
        len   = n;
        @(negedge clock);
        start = 1'b0;
        check("err_pulse", err, 1);
        check("err_pkt_valid", pkt_valid, 0);
        check("err_idle", idle, 1);
        @(negedge clock);
        check("err_clear", err, 0);
        check("err_pkt_valid2", pkt_valid, 0);
        check("err_idle2", idle, 1);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_pkt_valid", pkt_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_idle", idle, 1);
        reset = 1'b0;
        @(negedge clock);

        // Basic packet, then stalls, bad requests, corrupted parity.
        write_buf(6'd0, 8'hA5);
        write_buf(6'd1, 8'h3C);
        write_buf(6'd2, 8'h0F);
        run_packet(2'd1, 6'd3, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        run_packet(2'd1, 6'd3, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        try_bad(2'd3, 6'd4);
        try_bad(2'd0, 6'd0);
        run_packet(2'd1, 6'd3, 1'b1, 0, 1'b0, 1'b0, 1'b0);

        // Reset during payload byte 2, with writes attempted mid-packet.
        start = 1'b1;
        addr  = 2'd1;
        len   = 6'd3;
        @(negedge clock);
        start = 1'b0;
        check("rst_test_hdr", data_out, 8'h0D);
        @(negedge clock);
        check("rst_test_b1", data_out, 8'hA5);
        wr_en   = 1'b1;
        wr_addr = 6'd2;
        wr_data = 8'hEE;
        @(negedge clock);
        check("rst_test_b2", data_out, 8'h3C);
        wr_addr = 6'd1;
        wr_data = 8'hFF;
        reset   = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        wr_en = 1'b0;
        check("abort_pkt_valid", pkt_valid, 0);
        check("abort_data_out", data_out, 0);
        check("abort_idle", idle, 1);
        check("abort_done", done, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("abort_no_done", done, 0);
            check("abort_quiet", pkt_valid, 0);
        end
        run_packet(2'd1, 6'd3, 1'b0, 2, 1'b0, 1'b1, 1'b0);

        // Full-length packet, start held through the gap, then back-to-back.
        for (int i = 0; i < DEPTH; i++) begin
            write_buf(6'(i), 8'(i));
        end
        run_packet(2'd0, 6'd63, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        run_packet(2'd2, 6'd5, 1'b0, 0, 1'b0, 1'b0, 1'b1);

        for (int p = 0; p < 6; p++) begin
            for (int w = 0; w < 8; w++) begin
                write_buf(6'($urandom), 8'($urandom));
            end
            run_packet(2'($urandom_range(0, 2)), 6'($urandom_range(1, 63)),
                       1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)), 1'b1,
                       1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
